// File: rtl/cpu_fetch.sv
// Instruction-fetch stage: owns the PC, issues one-outstanding word reads,
// buffers returned words in an output slot plus 1-entry skid for decode.
module cpu_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_1000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_next_pc
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] rsp_npc_q, rsp_npc_d;
    logic        slot_valid_q, slot_valid_d;
    logic [31:0] slot_instr_q, slot_instr_d;
    logic [31:0] slot_npc_q, slot_npc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_npc_q, skid_npc_d;

    logic        rsp_live;
    logic        park;
    logic        req_ok;
    logic        req_fire;
    logic [31:0] redir_aligned;

    assign redir_aligned = redirect_pc & ~32'h3;

    // Response handling: a live response is one we still want (WAIT only);
    // it parks in the skid when decode holds a valid instruction.
    always_comb begin
        rsp_live = imem_rsp_valid && (state_q == S_WAIT);
        park     = rsp_live && stall && slot_valid_q;
    end

    // Request issue: skid empty, no redirect, and no response parking now,
    // since a further response could otherwise find the skid occupied.
    always_comb begin
        req_ok = reset
              && !skid_valid_q
              && !redirect_valid
              && !park
              && ((state_q == S_FETCH) || rsp_live);
        req_fire = req_ok && imem_req_ready;
    end

    assign imem_req_valid = req_ok;
    assign imem_req_addr  = pc_q;

    // FSM next state: tracks whether a response is outstanding and wanted.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH: begin
                if (req_fire) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    state_d = imem_rsp_valid ? S_FETCH : S_DRAIN;
                end else if (req_fire) begin
                    state_d = S_WAIT;
                end else if (imem_rsp_valid) begin
                    state_d = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (imem_rsp_valid) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // PC update, and next_PC of the request that goes outstanding.
    always_comb begin
        pc_d      = pc_q;
        rsp_npc_d = rsp_npc_q;
        if (redirect_valid) begin
            pc_d = redir_aligned;
        end else if (req_fire) begin
            pc_d = pc_q + 32'd4;
        end
        if (req_fire) begin
            rsp_npc_d = pc_q + 32'd4;
        end
    end

    // Output slot and skid buffer; redirect flushes both.
    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_instr_d = slot_instr_q;
        slot_npc_d   = slot_npc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_npc_d   = skid_npc_q;
        if (redirect_valid) begin
            slot_valid_d = 1'b0;
            slot_instr_d = NOP_INSTR;
            skid_valid_d = 1'b0;
        end else if (!stall) begin
            if (skid_valid_q) begin
                slot_valid_d = 1'b1;
                slot_instr_d = skid_instr_q;
                slot_npc_d   = skid_npc_q;
                skid_valid_d = 1'b0;
            end else if (rsp_live) begin
                slot_valid_d = 1'b1;
                slot_instr_d = imem_rsp_data;
                slot_npc_d   = rsp_npc_q;
            end else begin
                slot_valid_d = 1'b0;
                slot_instr_d = NOP_INSTR;
            end
        end else if (slot_valid_q) begin
            if (rsp_live) begin
                skid_valid_d = 1'b1;
                skid_instr_d = imem_rsp_data;
                skid_npc_d   = rsp_npc_q;
            end
        end else if (rsp_live) begin
            slot_valid_d = 1'b1;
            slot_instr_d = imem_rsp_data;
            slot_npc_d   = rsp_npc_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            rsp_npc_q    <= 32'd0;
            slot_valid_q <= 1'b0;
            slot_instr_q <= NOP_INSTR;
            slot_npc_q   <= 32'd0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= 32'd0;
            skid_npc_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            rsp_npc_q    <= rsp_npc_d;
            slot_valid_q <= slot_valid_d;
            slot_instr_q <= slot_instr_d;
            slot_npc_q   <= slot_npc_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_npc_q   <= skid_npc_d;
        end
    end

    assign dec_valid   = slot_valid_q;
    assign dec_instr   = slot_instr_q;
    assign dec_next_pc = slot_npc_q;

endmodule

// File: tb/tb_cpu_fetch.sv
// Bench for cpu_fetch: memory model, program-order scoreboard,
// directed scenarios and a randomized run.
module tb_cpu_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        stall;
    logic        redir;
    logic [31:0] redir_pc;
    logic        dv;
    logic [31:0] di;
    logic [31:0] dn;

    always #5 clk = ~clk;

    cpu_fetch dut (
        .clock          (clk),
        .reset          (rst_n),
        .imem_req_valid (req_valid),
        .imem_req_ready (req_ready),
        .imem_req_addr  (req_addr),
        .imem_rsp_valid (rsp_valid),
        .imem_rsp_data  (rsp_data),
        .stall          (stall),
        .redirect_valid (redir),
        .redirect_pc    (redir_pc),
        .dec_valid      (dv),
        .dec_instr      (di),
        .dec_next_pc    (dn)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    logic [31:0] fetch_pc, exp_pc;
    bit          mem_busy;
    logic [31:0] mem_addr;
    int          mem_cnt;
    int          lat_fix;
    bit          prev_hold, prev_redir;
    logic [31:0] prev_di, prev_dn;
    int          idle;

    // captured values of the last cycle run
    bit          c_req_v, c_rsp, c_dv, c_acc, c_cons;
    logic [31:0] c_req_a, c_di, c_dn;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return a ^ 32'h5A00_0013;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        fetch_pc   = 32'h1000;
        exp_pc     = 32'h1000;
        mem_busy   = 0;
        mem_cnt    = 0;
        prev_hold  = 0;
        prev_redir = 0;
        idle       = 0;
    endtask

    // one clock cycle: drive memory, check at negedge, advance model
    task automatic cycle();
        rsp_valid = 1'b0;
        rsp_data  = $urandom;
        if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                rsp_valid = 1'b1;
                rsp_data  = mem_word(mem_addr);
            end
        end
        if (!redir) redir_pc = $urandom;
        @(negedge clk);
        c_req_v = req_valid;
        c_req_a = req_addr;
        c_rsp   = rsp_valid;
        c_dv    = dv;
        c_di    = di;
        c_dn    = dn;
        c_acc   = req_valid && req_ready;
        c_cons  = dv && !stall;
        if (req_valid) chk("req_addr", req_addr, fetch_pc);
        if (redir) chk("req_in_redirect", {31'd0, req_valid}, 32'd0);
        if (!dv) chk("bubble_instr", di, 32'h0);
        if (prev_redir) chk("flush_bubble", {31'd0, dv}, 32'd0);
        if (prev_hold) begin
            chk("hold_valid", {31'd0, dv}, 32'd1);
            chk("hold_instr", di, prev_di);
            chk("hold_npc", dn, prev_dn);
        end
        if (dv && !stall) begin
            chk("order_instr", di, mem_word(exp_pc));
            chk("order_npc", dn, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            idle = 0;
        end else if (!stall && !redir) begin
            idle++;
            if (idle > 60) begin
                n_tests++;
                n_fail++;
                $display("FAIL liveness: got %0d idle cycles expected <= 60", idle);
                idle = 0;
            end
        end
        if (c_acc && mem_busy && !rsp_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL one_outstanding: got 2 requests expected 1");
        end
        if (rsp_valid) mem_busy = 0;
        if (c_acc) begin
            mem_busy = 1;
            mem_addr = req_addr;
            mem_cnt  = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 3));
            fetch_pc = fetch_pc + 32'd4;
        end
        if (redir) begin
            fetch_pc = redir_pc & ~32'h3;
            exp_pc   = redir_pc & ~32'h3;
        end
        prev_hold  = dv && stall && !redir;
        prev_redir = redir;
        prev_di    = di;
        prev_dn    = dn;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] held;
        bit found;
        req_ready = 1'b1;
        stall     = 1'b0;
        redir     = 1'b0;
        redir_pc  = 32'h0;
        rsp_valid = 1'b0;
        rsp_data  = 32'h0;
        lat_fix   = 1;
        model_reset();

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dv", {31'd0, dv}, 32'd0);
        chk("rst_instr", di, 32'h0);
        chk("rst_npc", dn, 32'h0);
        chk("rst_req", {31'd0, req_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // streaming from RESET_PC with 1-cycle memory
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (i == 0) begin
                chk("t1_req_v", {31'd0, c_req_v}, 32'd1);
                chk("t1_req_a", c_req_a, 32'h1000);
                chk("t1_dv0", {31'd0, c_dv}, 32'd0);
            end
            if (i == 1) chk("t1_dv1", {31'd0, c_dv}, 32'd0);
            if (i == 2) begin
                chk("t1_dv2", {31'd0, c_dv}, 32'd1);
                chk("t1_npc2", c_dn, 32'h1004);
                chk("t1_instr2", c_di, 32'h5A00_1013);
            end
            if (i == 3) chk("t1_npc3", c_dn, 32'h1008);
            if (i == 4) chk("t1_npc4", c_dn, 32'h100C);
        end

        // stall three cycles while streaming
        stall = 1'b1;
        held  = 32'h0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            if (k == 0) begin
                held = c_dn;
                chk("t2_dv", {31'd0, c_dv}, 32'd1);
            end
            chk("t2_no_req", {31'd0, c_req_v}, 32'd0);
        end
        stall = 1'b0;
        cycle();
        chk("t2_rel_npc", c_dn, held);
        cycle();
        chk("t2_skid_dv", {31'd0, c_dv}, 32'd1);
        chk("t2_skid_npc", c_dn, held + 32'd4);
        repeat (4) cycle();

        // redirect while WAIT with 3-cycle memory
        lat_fix = 3;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            found = c_acc;
        end
        chk("t3_got_acc", {31'd0, found}, 32'd1);
        redir    = 1'b1;
        redir_pc = 32'h2003;
        cycle();
        redir = 1'b0;
        chk("t3_no_rsp", {31'd0, c_rsp}, 32'd0);
        cycle();
        chk("t3_bubble", {31'd0, c_dv}, 32'd0);
        found = c_acc;
        if (found) chk("t3_req_a", c_req_a, 32'h2000);
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            found = c_acc;
            if (found) chk("t3_req_a", c_req_a, 32'h2000);
        end
        chk("t3_req_seen", {31'd0, found}, 32'd1);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            found = c_cons;
            if (found) begin
                chk("t3_npc", c_dn, 32'h2004);
                chk("t3_instr", c_di, 32'h5A00_2013);
            end
        end
        chk("t3_out_seen", {31'd0, found}, 32'd1);

        // redirect coinciding with a response under stall
        lat_fix = 1;
        repeat (8) cycle();
        stall    = 1'b1;
        redir    = 1'b1;
        redir_pc = 32'h3000;
        cycle();
        redir = 1'b0;
        chk("t4_rsp", {31'd0, c_rsp}, 32'd1);
        cycle();
        chk("t4_dv", {31'd0, c_dv}, 32'd0);
        chk("t4_req_v", {31'd0, c_req_v}, 32'd1);
        chk("t4_req_a", c_req_a, 32'h3000);
        stall = 1'b0;
        repeat (6) cycle();

        // memory not ready for 4 cycles after reset
        #2;
        rst_n     = 1'b0;
        rsp_valid = 1'b0;
        req_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t5_req_v", {31'd0, c_req_v}, 32'd1);
            chk("t5_req_a", c_req_a, 32'h1000);
            chk("t5_dv", {31'd0, c_dv}, 32'd0);
        end
        req_ready = 1'b1;
        repeat (6) cycle();

        // asynchronous reset with a word parked in the skid
        stall = 1'b1;
        repeat (2) cycle();
        chk("t6_pre_dv", {31'd0, c_dv}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_dv", {31'd0, dv}, 32'd0);
        chk("t6_instr", di, 32'h0);
        chk("t6_npc", dn, 32'h0);
        chk("t6_req", {31'd0, req_valid}, 32'd0);
        rsp_valid = 1'b0;
        stall     = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();
        chk("t6_req_v", {31'd0, c_req_v}, 32'd1);
        chk("t6_req_a", c_req_a, 32'h1000);
        repeat (6) cycle();

        // randomized run
        lat_fix = 0;
        for (int i = 0; i < 3000; i++) begin
            req_ready = ($urandom % 4) != 0;
            stall     = ($urandom % 10) < 3;
            redir     = ($urandom % 25) == 0;
            if (redir) redir_pc = $urandom_range(0, 32'hFFFF);
            cycle();
        end
        redir = 1'b0;
        stall = 1'b0;
        repeat (10) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
